fp_accumulator: RTL and testbench

- Sequential stream front-end for the combinational single-precision adder fp_adder.
- Accepts a packet of IEEE-754 single-precision values over a valid/ready stream and buffers them in a small FIFO.
- Folds each value into a running sum register through one fp_adder instance, one element per cycle.
- Presents the packet total, element count and a special-value flag on a valid/ready output.

---
 rtl/fp_pkg.sv | 13 +
 rtl/acc_fifo.sv | 36 +++
 rtl/fp_adder.sv | 70 +++++++
 rtl/fp_accumulator.sv | 90 +++++++++
 tb/tb_fp_accumulator.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared constants and FSM state type for the single-precision accumulator path.
package fp_pkg;
  localparam int          FP_W           = 32;
  localparam logic [7:0]  EXP_SPECIAL    = 8'hFF;
  localparam logic [31:0] FP_ZERO        = 32'h0;
  localparam logic [31:0] FP_SPECIAL_OUT = 32'h7FFF_FFFF;

  typedef enum logic {ACC, DONE} state_t;

  function automatic logic is_special(input logic [FP_W-1:0] x);
    return x[30:23] == EXP_SPECIAL;
  endfunction
endpackage

// File: rtl/acc_fifo.sv
// Synchronous FIFO, pointers with an extra wrap bit; no write-through bypass.
module acc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr, r_rd;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);
  assign o_data  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push && !o_full) r_wr <= r_wr + 1'b1;
      if (i_pop && !o_empty) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk)
    if (i_push && !o_full) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/fp_adder.sv
// Combinational single-precision adder: truncating normalisation, Inf/NaN and
// overflow collapse to FP_SPECIAL_OUT, a zero operand passes the other through.
module fp_adder
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] i_a,
  input  logic [FP_W-1:0] i_b,
  output logic [FP_W-1:0] o_sum
);
  logic [FP_W-1:0] w_big, w_small;
  logic [7:0]      w_eb, w_es, w_diff, w_sh;
  logic [23:0]     w_mb, w_ms, w_mal, w_d, w_m;
  logic [24:0]     w_s;
  logic [8:0]      w_e;
  logic [4:0]      w_lz;

  always_comb begin
    o_sum  = FP_ZERO;
    w_big  = i_a;
    w_small = i_b;
    if (i_b[30:0] > i_a[30:0]) begin
      w_big   = i_b;
      w_small = i_a;
    end
    // Denormals use exponent 1 with no hidden bit.
    w_eb   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
    w_es   = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
    w_mb   = {w_big[30:23] != 8'd0, w_big[22:0]};
    w_ms   = {w_small[30:23] != 8'd0, w_small[22:0]};
    w_diff = w_eb - w_es;
    w_mal  = (w_diff > 8'd23) ? 24'd0 : (w_ms >> w_diff);
    w_s    = 25'd0;
    w_d    = 24'd0;
    w_lz   = 5'd24;
    w_sh   = 8'd0;
    w_m    = 24'd0;
    w_e    = 9'd0;

    if (w_big[31] == w_small[31]) begin
      w_s = {1'b0, w_mb} + {1'b0, w_mal};
      if (w_s[24]) begin
        w_m = w_s[24:1];
        w_e = {1'b0, w_eb} + 9'd1;
      end else begin
        w_m = w_s[23:0];
        w_e = {1'b0, w_eb};
      end
    end else begin
      w_d = w_mb - w_mal;
      for (int i = 0; i < 24; i++)
        if (w_d[i]) w_lz = 5'(23 - i);
      w_sh = ({3'b0, w_lz} >= w_eb) ? (w_eb - 8'd1) : {3'b0, w_lz};
      w_m  = w_d << w_sh;
      w_e  = {1'b0, w_eb - w_sh};
    end

    if (is_special(i_a) || is_special(i_b))
      o_sum = FP_SPECIAL_OUT;
    else if (i_a[30:0] == 31'd0)
      o_sum = i_b;
    else if (i_b[30:0] == 31'd0)
      o_sum = i_a;
    else if (w_e >= 9'd255)
      o_sum = FP_SPECIAL_OUT;
    else if (w_m == 24'd0)
      o_sum = FP_ZERO;
    else
      o_sum = {w_big[31], (w_m[23] ? w_e[7:0] : 8'd0), w_m[22:0]};
  end
endmodule

// File: rtl/fp_accumulator.sv
// Stream front-end: buffers a packet, folds one element per cycle into a
// running fp sum, and offers total/count/special on a valid/ready output.
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_special,
  output logic             busy
);
  state_t           r_state, w_nstate;
  logic [FP_W-1:0]  r_acc, w_nacc, w_sum;
  logic [CNT_W-1:0] r_cnt, w_ncnt;
  logic             r_special, w_nspecial;
  logic             w_full, w_empty, w_pop;
  logic [FP_W:0]    w_head;

  acc_fifo #(.DEPTH(DEPTH), .W(FP_W + 1)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (in_valid),
    .i_data  ({in_last, in_data}),
    .o_full  (w_full),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty)
  );

  fp_adder u_add (
    .i_a   (r_acc),
    .i_b   (w_head[FP_W-1:0]),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ACC;
      r_acc     <= FP_ZERO;
      r_cnt     <= '0;
      r_special <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_acc     <= w_nacc;
      r_cnt     <= w_ncnt;
      r_special <= w_nspecial;
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_nacc     = r_acc;
    w_ncnt     = r_cnt;
    w_nspecial = r_special;
    w_pop      = 1'b0;
    case (r_state)
      ACC: if (!w_empty) begin
        w_pop      = 1'b1;
        w_nacc     = w_sum;
        w_ncnt     = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        w_nspecial = r_special | is_special(w_head[FP_W-1:0]) | is_special(w_sum);
        if (w_head[FP_W]) w_nstate = DONE;
      end
      DONE: if (out_ready) begin
        w_nacc     = FP_ZERO;
        w_ncnt     = '0;
        w_nspecial = 1'b0;
        w_nstate   = ACC;
      end
      default: w_nstate = ACC;
    endcase
  end

  assign in_ready    = !w_full;
  assign out_valid   = (r_state == DONE);
  assign out_sum     = r_acc;
  assign out_count   = r_cnt;
  assign out_special = r_special;
  assign busy        = (r_state == DONE) || (r_cnt != '0);
endmodule

// File: tb/tb_fp_accumulator.sv
// Directed bench for fp_accumulator: packet sums, latency, specials,
// backpressure through a full FIFO, and reset in the middle of a packet.
module tb_fp_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic [15:0] out_count;
  logic        out_special;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  fp_accumulator #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_special(out_special), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic drive_beat(input logic [31:0] d, input logic l);
    bit ok = 0;
    int guard = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!ok && guard < 50) begin
      ok = in_ready;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL accept_timeout: in_ready stuck low, data %h", d);
    end
  endtask

  task automatic wait_valid();
    int guard = 0;
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid) begin
      n_total++;
      $display("FAIL valid_timeout: out_valid never rose");
    end
  endtask

  task automatic test_reset();
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_sum !== 32'h0) $display("FAIL rst_sum: got %h want 0", out_sum); else n_pass++;
    n_total++; if (out_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", out_count); else n_pass++;
    n_total++; if (out_special !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_flags: got special=%b busy=%b want 0 0", out_special, busy); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive_beat(32'h3F80_0000, 1'b0);
    drive_beat(32'h4000_0000, 1'b0);
    drive_beat(32'h3F00_0000, 1'b1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (busy !== 1'b1 || out_count !== 16'd2)
      $display("FAIL basic_busy: got busy=%b count=%0d want 1 2", busy, out_count); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1) $display("FAIL basic_latency: got %b want 1", out_valid); else n_pass++;
    n_total++; if (out_sum !== 32'h4060_0000) $display("FAIL basic_sum: got %h want 40600000", out_sum); else n_pass++;
    n_total++; if (out_count !== 16'd3) $display("FAIL basic_count: got %0d want 3", out_count); else n_pass++;
    n_total++; if (out_special !== 1'b0) $display("FAIL basic_special: got %b want 0", out_special); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b0 || out_count !== 16'd0 || out_sum !== 32'h0 || busy !== 1'b0)
      $display("FAIL basic_clear: got v=%b cnt=%0d sum=%h busy=%b want 0 0 0 0",
               out_valid, out_count, out_sum, busy); else n_pass++;
  endtask

  task automatic test_single();
    drive_beat(32'h4040_0000, 1'b1);
    n_total++; if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", out_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (out_valid !== 1'b1 || out_sum !== 32'h4040_0000 || out_count !== 16'd1)
      $display("FAIL single_result: got v=%b sum=%h cnt=%0d want 1 40400000 1",
               out_valid, out_sum, out_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_cancel();
    drive_beat(32'h3F80_0000, 1'b0);
    drive_beat(32'hBF80_0000, 1'b1);
    wait_valid();
    n_total++; if (out_sum !== 32'h0 || out_count !== 16'd2)
      $display("FAIL cancel_result: got sum=%h cnt=%0d want 00000000 2", out_sum, out_count); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_special();
    drive_beat(32'h7F80_0000, 1'b0);
    drive_beat(32'h3F80_0000, 1'b1);
    wait_valid();
    n_total++; if (out_sum !== 32'h7FFF_FFFF) $display("FAIL special_sum: got %h want 7fffffff", out_sum); else n_pass++;
    n_total++; if (out_special !== 1'b1 || out_count !== 16'd2)
      $display("FAIL special_flag: got special=%b cnt=%0d want 1 2", out_special, out_count); else n_pass++;
    @(negedge clk);
    drive_beat(32'h3F80_0000, 1'b1);
    wait_valid();
    n_total++; if (out_special !== 1'b0 || out_sum !== 32'h3F80_0000)
      $display("FAIL special_clear: got special=%b sum=%h want 0 3f800000", out_special, out_sum); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [31:0] beats [6];
    int idx = 0;
    int n_acc = 0;
    bit ok;
    beats = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000,
              32'h4000_0000, 32'h4000_0000};
    out_ready = 1'b0;
    drive_beat(32'h3F80_0000, 1'b1);
    wait_valid();
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_data = beats[idx]; in_last = (idx == 3);
      ok = in_ready;
      @(negedge clk);
      if (ok) begin
        n_acc++;
        if (idx < 5) idx++;
      end
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_total++; if (n_acc != 4) $display("FAIL bp_accepted: got %0d want 4", n_acc); else n_pass++;
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_full: got in_ready=%b want 0", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || out_sum !== 32'h3F80_0000 || out_count !== 16'd1)
      $display("FAIL bp_hold: got v=%b sum=%h cnt=%0d want 1 3f800000 1",
               out_valid, out_sum, out_count); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL bp_release: got in_ready=%b v=%b want 0 0", in_ready, out_valid); else n_pass++;
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_resume: got in_ready=%b want 1", in_ready); else n_pass++;
    wait_valid();
    n_total++; if (out_sum !== 32'h4080_0000 || out_count !== 16'd4)
      $display("FAIL bp_sum: got sum=%h cnt=%0d want 40800000 4", out_sum, out_count); else n_pass++;
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    drive_beat(32'h3F80_0000, 1'b0);
    drive_beat(32'h4000_0000, 1'b0);
    drive_beat(32'h4080_0000, 1'b0);
    n_total++; if (out_count !== 16'd2 || out_sum !== 32'h4040_0000)
      $display("FAIL mid_partial: got cnt=%0d sum=%h want 2 40400000", out_count, out_sum); else n_pass++;
    rst = 1'b1;
    #1;
    n_total++; if (out_count !== 16'd0 || out_sum !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL mid_reset: got cnt=%0d sum=%h busy=%b in_ready=%b v=%b want 0 0 0 1 0",
               out_count, out_sum, busy, in_ready, out_valid); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_beat(32'h4000_0000, 1'b1);
    wait_valid();
    n_total++; if (out_sum !== 32'h4000_0000 || out_count !== 16'd1)
      $display("FAIL mid_after: got sum=%h cnt=%0d want 40000000 1", out_sum, out_count); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_single();
    test_cancel();
    test_special();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end
endmodule
